// File: rtl/reg_to_apb_pkg.sv
// Shared types for the regbus-to-APB demux: FSM states, default bus structs, fixed PPROT.
package reg_to_apb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DECERR} state_e;

  localparam logic [2:0]  PPROT_DEFAULT = 3'b010;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned NUM_SLV       = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                write;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                valid;
  } reg_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   paddr;
    logic [2:0]          pprot;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;
  } apb_rsp_t;

  typedef struct packed {
    logic [$clog2(NUM_SLV)-1:0] idx;
    logic [ADDR_W-1:0]          start_addr;
    logic [ADDR_W-1:0]          end_addr;
  } rule_t;

endpackage

// File: rtl/addr_decode.sv
// Rule-table lookup: end address exclusive, lowest matching rule wins, out-of-range idx misses.
module addr_decode #(
  parameter int unsigned NumSlaves = 4,
  parameter int unsigned NumRules  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdxW      = 2,
  parameter type         rule_t    = reg_to_apb_pkg::rule_t
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  rule_t [NumRules-1:0] addr_map_i,
  output logic [IdxW-1:0]      idx_o,
  output logic                 dec_valid_o
);

  always_comb begin
    idx_o       = '0;
    dec_valid_o = 1'b0;
    // Walk from the top so the lowest-indexed match is the last one written.
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (addr_i >= addr_map_i[i].start_addr && addr_i < addr_map_i[i].end_addr &&
          32'(addr_map_i[i].idx) < NumSlaves) begin
        idx_o       = IdxW'(addr_map_i[i].idx);
        dec_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_to_apb_timeout.sv
// ACCESS-phase watchdog: counts cycles without pready and flags expiry on the last allowed cycle.
module reg_to_apb_timeout #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = inc_i && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)                    cnt_d = '0;
    else if (inc_i && !expired_o)   cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_to_apb_demux.sv
// Regbus-to-APB bridge fanning out to NumSlaves completers via a runtime address map.
// Define REG_TO_APB_DEMUX_TIMEOUT_EN to bound the ACCESS phase to TimeoutCycles cycles.
module reg_to_apb_demux #(
  parameter int unsigned NumSlaves     = 4,
  parameter int unsigned NumRules      = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type reg_req_t = reg_to_apb_pkg::reg_req_t,
  parameter type reg_rsp_t = reg_to_apb_pkg::reg_rsp_t,
  parameter type apb_req_t = reg_to_apb_pkg::apb_req_t,
  parameter type apb_rsp_t = reg_to_apb_pkg::apb_rsp_t,
  parameter type rule_t    = reg_to_apb_pkg::rule_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  reg_req_t                 reg_req_i,
  output reg_rsp_t                 reg_rsp_o,
  input  rule_t    [NumRules-1:0]  addr_map_i,
  output apb_req_t [NumSlaves-1:0] apb_req_o,
  input  apb_rsp_t [NumSlaves-1:0] apb_rsp_i
);
  import reg_to_apb_pkg::*;

  localparam int unsigned IdxW  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
  localparam int unsigned StrbW = DataWidth / 8;

  if (NumSlaves < 1 || NumRules < 1 || TimeoutCycles < 2) begin : g_bad_cfg
    $error("reg_to_apb_demux: invalid parameterisation");
  end

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        sel_q, sel_d, dec_idx;
  logic                   dec_hit, start_access, pready_sel, timeout;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic [StrbW-1:0]       wstrb;

  assign addr  = reg_req_i.addr;
  assign wdata = reg_req_i.wdata;
  assign wstrb = reg_req_i.wstrb;

  addr_decode #(
    .NumSlaves (NumSlaves),
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxW      (IdxW),
    .rule_t    (rule_t)
  ) i_addr_decode (
    .addr_i      (addr),
    .addr_map_i  (addr_map_i),
    .idx_o       (dec_idx),
    .dec_valid_o (dec_hit)
  );

  assign start_access = (state_q == IDLE) && reg_req_i.valid && dec_hit;
  assign pready_sel   = apb_rsp_i[sel_q].pready;

`ifdef REG_TO_APB_DEMUX_TIMEOUT_EN
  reg_to_apb_timeout #(
    .TimeoutCycles (TimeoutCycles)
  ) i_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_access),
    .inc_i     ((state_q == ACCESS) && !pready_sel),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: if (reg_req_i.valid) begin
        if (dec_hit) begin
          state_d = ACCESS;
          sel_d   = (NumSlaves > 1) ? dec_idx : '0;
        end else begin
          state_d = DECERR;
        end
      end
      ACCESS:  if (pready_sel || timeout) state_d = IDLE;
      DECERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload is broadcast; only the selected completer ever sees psel/penable.
  always_comb begin
    reg_rsp_o = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      apb_req_o[i]         = '0;
      apb_req_o[i].paddr   = addr;
      apb_req_o[i].pprot   = PPROT_DEFAULT;
      apb_req_o[i].pwrite  = reg_req_i.write;
      apb_req_o[i].pwdata  = wdata;
      apb_req_o[i].pstrb   = wstrb;
    end
    unique case (state_q)
      IDLE: if (start_access) apb_req_o[sel_d].psel = 1'b1;
      ACCESS: begin
        apb_req_o[sel_q].psel    = 1'b1;
        apb_req_o[sel_q].penable = 1'b1;
        if (pready_sel) begin
          reg_rsp_o.ready = 1'b1;
          reg_rsp_o.error = apb_rsp_i[sel_q].pslverr;
          reg_rsp_o.rdata = apb_rsp_i[sel_q].prdata;
        end else if (timeout) begin
          reg_rsp_o.ready = 1'b1;
          reg_rsp_o.error = 1'b1;
        end
      end
      DECERR: begin
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = 1'b1;
      end
      default: ;
    endcase
  end

  valid_held_until_ready: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    reg_req_i.valid && !reg_rsp_o.ready |=> reg_req_i.valid
  );

endmodule

// File: tb/tb_reg_to_apb_demux.sv
// Vector table plus scoreboard for reg_to_apb_demux, with behavioural APB completers.
module tb_reg_to_apb_demux;
  import reg_to_apb_pkg::*;

  localparam int NS = 4;
  localparam int NR = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  reg_req_t            req;
  reg_rsp_t            rsp;
  rule_t    [NR-1:0]   map;
  apb_req_t [NS-1:0]   apb_req;
  apb_rsp_t [NS-1:0]   apb_rsp;

  always #5 clk_i = ~clk_i;

  reg_to_apb_demux #(
    .NumSlaves (NS), .NumRules (NR), .AddrWidth (32), .DataWidth (32), .TimeoutCycles (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .reg_req_i  (req),
    .reg_rsp_o  (rsp),
    .addr_map_i (map),
    .apb_req_o  (apb_req),
    .apb_rsp_i  (apb_rsp)
  );

  // Completer model: pready after rwait ACCESS cycles, same response for every completer.
  int unsigned rwait;
  logic [31:0] rdat;
  logic        rerr;
  int unsigned acnt [NS];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      apb_rsp[i].pready  = apb_req[i].psel && apb_req[i].penable && (acnt[i] == rwait);
      apb_rsp[i].prdata  = rdat;
      apb_rsp[i].pslverr = rerr && apb_rsp[i].pready;
    end
  end

  always @(posedge clk_i) begin
    for (int i = 0; i < NS; i++) begin
      if (apb_req[i].psel && apb_req[i].penable && !apb_rsp[i].pready) acnt[i] <= acnt[i] + 1;
      else                                                               acnt[i] <= 0;
    end
  end

  typedef struct {
    logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb;
    int unsigned waits; logic [31:0] prdata; logic perr;
    logic [3:0] exp_mask; logic [31:0] exp_rdata; logic exp_err; int exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] mask; logic [31:0] rdata; logic err; int lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] ws,
                              int unsigned wt, logic [31:0] pd, logic pe,
                              logic [3:0] m, logic [31:0] er, logic ee, int el);
    vec_t v;
    v.addr = a; v.write = w; v.wdata = wd; v.wstrb = ws; v.waits = wt; v.prdata = pd;
    v.perr = pe; v.exp_mask = m; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  function automatic logic [3:0] psel_mask();
    logic [3:0] m;
    for (int i = 0; i < NS; i++) m[i] = apb_req[i].psel;
    return m;
  endfunction

  function automatic logic [3:0] pen_mask();
    logic [3:0] m;
    for (int i = 0; i < NS; i++) m[i] = apb_req[i].penable;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves valid high so the next call is back-to-back.
  task automatic run_vec(input vec_t v, input int n);
    exp_t e, g;
    int cyc; bit done; bit setup_ok; logic [3:0] mask;
    rwait = v.waits; rdat = v.prdata; rerr = v.perr;
    req.addr = v.addr; req.write = v.write; req.wdata = v.wdata; req.wstrb = v.wstrb;
    req.valid = 1'b1;
    e.mask = v.exp_mask; e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sb_q.push_back(e);
    cyc = 0; done = 0; setup_ok = 1; mask = '0;
    while (!done && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      mask |= psel_mask();
      if ((pen_mask() & ~psel_mask()) != 0) setup_ok = 0;
      if (cyc == 1) begin
        if (pen_mask() != 0) setup_ok = 0;
        for (int i = 0; i < NS; i++)
          if (apb_req[i].paddr !== v.addr || apb_req[i].pwrite !== v.write ||
              apb_req[i].pwdata !== v.wdata || apb_req[i].pstrb !== v.wstrb ||
              apb_req[i].pprot !== 3'b010) setup_ok = 0;
      end
      if (rsp.ready) done = 1;
    end
    if (!done) begin
      chk($sformatf("v%0d_no_ready", n), 64'(cyc), 64'(v.exp_lat));
      void'(sb_q.pop_front());
    end else begin
      g = sb_q.pop_front();
      chk($sformatf("v%0d_latency", n), 64'(cyc), 64'(g.lat));
      chk($sformatf("v%0d_rdata", n), 64'(rsp.rdata), 64'(g.rdata));
      chk($sformatf("v%0d_error", n), 64'(rsp.error), 64'(g.err));
      chk($sformatf("v%0d_psel_mask", n), 64'(mask), 64'(g.mask));
      chk($sformatf("v%0d_setup_phase", n), 64'(setup_ok), 64'd1);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req = '0;
    rwait = 0; rdat = '0; rerr = 1'b0;
    map[0] = '{idx: 2'd0, start_addr: 32'h0000, end_addr: 32'h1000};
    map[1] = '{idx: 2'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    map[2] = '{idx: 2'd2, start_addr: 32'h1800, end_addr: 32'h3000};
    map[3] = '{idx: 2'd3, start_addr: 32'h4000, end_addr: 32'h5000};

    vecs.push_back(mk(32'h1004, 0, 0,            4'h0, 3, 32'hCAFE,     0, 4'b0010, 32'hCAFE,     0, 5));
    vecs.push_back(mk(32'h0008, 1, 32'h55,       4'h1, 0, 32'h0,        0, 4'b0001, 32'h0,        0, 2));
    vecs.push_back(mk(32'h8000, 0, 0,            4'h0, 0, 32'h1111,     0, 4'b0000, 32'h0,        1, 2));
    vecs.push_back(mk(32'h0010, 0, 0,            4'h0, 0, 32'h1234,     1, 4'b0001, 32'h1234,     1, 2));
    vecs.push_back(mk(32'h1ffc, 0, 0,            4'h0, 1, 32'hBEEF,     0, 4'b0010, 32'hBEEF,     0, 3));
    vecs.push_back(mk(32'h1800, 0, 0,            4'h0, 0, 32'h1818,     0, 4'b0010, 32'h1818,     0, 2));
    vecs.push_back(mk(32'h2000, 0, 0,            4'h0, 0, 32'h2222,     0, 4'b0100, 32'h2222,     0, 2));
    vecs.push_back(mk(32'h2ffc, 0, 0,            4'h0, 2, 32'h2FFC,     0, 4'b0100, 32'h2FFC,     0, 4));
    vecs.push_back(mk(32'h3000, 0, 0,            4'h0, 0, 32'h3333,     0, 4'b0000, 32'h0,        1, 2));
    vecs.push_back(mk(32'h4ffc, 1, 32'hDEADBEEF, 4'hF, 7, 32'h0,        0, 4'b1000, 32'h0,        0, 9));
    vecs.push_back(mk(32'h4000, 0, 0,            4'h0, 0, 32'hA5A5A5A5, 0, 4'b1000, 32'hA5A5A5A5, 0, 2));
    vecs.push_back(mk(32'h0ffc, 1, 32'h1,        4'h3, 1, 32'h77,       1, 4'b0001, 32'h77,       1, 3));
`ifdef REG_TO_APB_DEMUX_TIMEOUT_EN
    vecs.push_back(mk(32'h0004, 0, 0,            4'h0, 1000, 32'hDEAD,  0, 4'b0001, 32'h0,        1, 9));
`else
    vecs.push_back(mk(32'h0004, 0, 0,            4'h0, 20, 32'h600D,    0, 4'b0001, 32'h600D,     0, 22));
`endif

    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(rsp.ready), 64'd0);
    chk("rst_error", 64'(rsp.error), 64'd0);
    chk("rst_rdata", 64'(rsp.rdata), 64'd0);
    chk("rst_psel",  64'({psel_mask(), pen_mask()}), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 64'(rsp.ready), 64'd0);
    @(posedge clk_i); #1;

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);
    req.valid = 1'b0;
    @(negedge clk_i);
    chk("after_last_psel", 64'({psel_mask(), pen_mask()}), 64'd0);
    chk("after_last_ready", 64'(rsp.ready), 64'd0);

    // Reset asserted in the middle of an ACCESS phase.
    @(posedge clk_i); #1;
    rwait = 1000; rdat = 32'h0; rerr = 1'b0;
    req.addr = 32'h1004; req.write = 1'b0; req.wdata = '0; req.wstrb = '0; req.valid = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_access", 64'({psel_mask(), pen_mask()}), 64'({4'b0010, 4'b0010}));
    #2;
    rst_ni = 1'b0;
    req.valid = 1'b0;
    #1;
    chk("mid_rst_apb_idle", 64'({psel_mask(), pen_mask()}), 64'd0);
    chk("mid_rst_ready", 64'(rsp.ready), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run_vec(mk(32'h1004, 0, 0, 4'h0, 0, 32'hF00D, 0, 4'b0010, 32'hF00D, 0, 2), 100);
    req.valid = 1'b0;
    @(negedge clk_i);
    chk("post_rst_idle", 64'({psel_mask(), pen_mask()}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
